serial_word_loader: RTL and testbench
=====================================

# serial_word_loader

Serial-to-parallel front end for the 16-bit `Register`. It accepts one bit per handshake from a serial source such as a debug/boot link or a bit-banged GPIO, and assembles a full word. When the word is complete it drives the word onto `word_out` and pulses `load` for exactly one cycle. `word_out` and `load` connect directly to the register's `in` and `load`.

## Interface
Parameters:
- `WIDTH`, 16: word width; must match the downstream register width.
- `MSB_FIRST`, 1: 1 = first received bit lands in `word_out[WIDTH-1]`; 0 = first bit lands in `word_out[0]`.

Ports:
- `clk`  in  1  single system clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `bit_in`  in  1  serial data bit.
- `bit_valid`  in  1  `bit_in` is valid this cycle.
- `bit_ready`  out  1  the block accepts a bit this cycle.
- `word_out`  out  WIDTH  last committed word; feeds register `in`.
- `load`  out  1  one-cycle commit strobe; feeds register `load`.
- `busy`  out  1  a frame is in progress (state ≠ IDLE).
- `frame_err`  out  1  one-cycle parity-failure pulse; tied 0 without `SERIAL_LOADER_PARITY_EN`.

## Operation
- **Transfer:** a bit transfers on a cycle where `bit_valid && bit_ready`. When `bit_ready` is 0, `bit_valid` is ignored; the source holds its bit.
- **States:** IDLE, SHIFT, PARITY (present only with the macro), COMMIT.
- **IDLE:** `bit_ready`=1. On a transfer, the bit enters the shift register, `count`=1, next state SHIFT.
- **SHIFT:** `bit_ready`=1. Each transfer shifts in one bit and increments `count`. The transfer that brings `count` to WIDTH moves to PARITY if the macro is defined, otherwise to COMMIT.
- **PARITY:** `bit_ready`=1. The next transfer is an even-parity bit over the WIDTH data bits.
  - Match: next state COMMIT.
  - Mismatch: `frame_err`=1 for one cycle, partial word discarded, no `load`, next state IDLE.
- **COMMIT:** `bit_ready`=0. `word_out` is registered from the shift register, `load`=1 for this cycle only, next state IDLE.
- **Shift direction:**
  - `MSB_FIRST`=1: shift left, new bit enters at bit 0.
  - `MSB_FIRST`=0: shift right, new bit enters at bit WIDTH-1.
- **Counter:** `count` width is `$clog2(WIDTH+1)`. It never exceeds WIDTH and clears on entering IDLE.
- **`word_out`:** changes only in COMMIT and holds its value otherwise, including across error frames.
- **Gaps:** arbitrary gaps between transfers are legal. There is no timeout.

## Timing
- **Reset values:** state IDLE, `word_out`=0, `load`=0, `busy`=0, `frame_err`=0, `bit_ready`=1; shift register and `count` cleared.
- **Reset mid-frame:** the partial word is discarded and no `load` is issued. Reset has priority over every other event.
- **Load latency:** `load` and the new `word_out` are valid in the cycle immediately after the final data bit (or parity bit) transfer. The downstream register therefore captures the word on the edge that ends the COMMIT cycle.
- **Throughput:** a word takes WIDTH transfers (WIDTH+1 with parity) plus one COMMIT bubble. A bit offered during COMMIT waits one cycle and is not lost.
- **Status outputs:** `busy` is registered and is 1 in SHIFT, PARITY and COMMIT. `bit_ready` is decoded from the state register (no combinational path from `bit_valid`).

## Configuration
- Macro: `SERIAL_LOADER_PARITY_EN`.
- **Defined:** the PARITY state exists, each frame is WIDTH+1 bits, and `frame_err` is active.
- **Undefined:** no PARITY state, frame is WIDTH bits, and `frame_err` is a constant 0. The port remains present in both builds.

## Structure
- **Shared include `serial_loader_defs.vh`:** state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_PARITY=2'd2, ST_COMMIT=2'd3, and the default WIDTH constant.
- **Sub-module `serial_shifter`:** the WIDTH-bit shift register plus bit counter and running parity. It has inputs `clk`, `reset`, `shift_en`, `clear`, `bit_in` and outputs `data`, `count`, `parity`.
- **Top level:** FSM, `word_out` register, and strobes.

## Test plan
- **Basic word:** after reset, shift 0xA5C3 MSB-first with `bit_valid` held high → `load`=1 for exactly one cycle, one cycle after bit 16; `word_out`=0xA5C3; `busy`=1 from the first bit through COMMIT.
- **Gapped input:** send 0x0001 with `bit_valid` asserted every third cycle → single `load`, `word_out`=0x0001, no early strobe.
- **Back-to-back words:** send 0xFFFF then 0x1234 with `bit_valid` held high → `bit_ready`=0 only in the COMMIT cycle, no bit dropped, two `load` pulses, `word_out` sequence 0xFFFF then 0x1234.
- **Reset mid-frame:** assert `reset` after 7 bits → all outputs return to reset values and no `load` is issued; a following word 0x00FF then loads as 0x00FF.
- **Parity (`SERIAL_LOADER_PARITY_EN`):** 0x0003 + parity 0 → `load`, `word_out`=0x0003; 0x0007 + parity 0 → `frame_err` pulse, no `load`, `word_out` stays 0x0003.
- **LSB-first (`MSB_FIRST`=0):** bits 1,0,…,0 (16 total) → `word_out`=0x0001.

Source files
------------

// File: rtl/serial_word_loader_pkg.sv
// Shared constants for serial_word_loader: state encodings and the default word width.
// The optional parity stage is enabled by defining SERIAL_LOADER_PARITY_EN.
package serial_word_loader_pkg;

  localparam int unsigned DefaultWidth = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  function automatic logic in_frame(input logic [1:0] st);
    return st != ST_IDLE;
  endfunction

endpackage

// File: rtl/serial_shifter.sv
// WIDTH-bit shift register with bit counter and running parity for serial_word_loader.
// clear wins over held state; clear together with shift_en starts a fresh word with this bit.
module serial_shifter #(
  parameter int unsigned WIDTH     = 16,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned CountW    = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shift_en,
  input  logic              clear,
  input  logic              bit_in,
  output logic [WIDTH-1:0]  data,
  output logic [CountW-1:0] count,
  output logic              parity
);

  logic [WIDTH-1:0]  data_q, data_d;
  logic [CountW-1:0] count_q, count_d;
  logic              parity_q, parity_d;

  always_comb begin
    data_d   = clear ? '0 : data_q;
    count_d  = clear ? '0 : count_q;
    parity_d = clear ? 1'b0 : parity_q;
    if (shift_en) begin
      if (MSB_FIRST) begin
        data_d = {data_d[WIDTH-2:0], bit_in};
      end else begin
        data_d = {bit_in, data_d[WIDTH-1:1]};
      end
      count_d  = count_d + CountW'(1);
      parity_d = parity_d ^ bit_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q   <= '0;
      count_q  <= '0;
      parity_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      count_q  <= count_d;
      parity_q <= parity_d;
    end
  end

  assign data   = data_q;
  assign count  = count_q;
  assign parity = parity_q;

endmodule

// File: rtl/serial_word_loader.sv
// Serial-to-parallel loader: assembles WIDTH bits into a word and pulses load for one cycle.
// Define SERIAL_LOADER_PARITY_EN to add a trailing even-parity bit and the frame_err pulse.
module serial_word_loader
  import serial_word_loader_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [WIDTH-1:0] word_out,
  output logic             load,
  output logic             busy,
  output logic             frame_err
);

  localparam int unsigned CountW = $clog2(WIDTH + 1);

  logic [1:0]        state_q, state_d;
  logic [WIDTH-1:0]  word_q, word_d;
  logic              busy_q;
  logic              shift_en, clear, transfer, last_bit;
  logic [WIDTH-1:0]  sh_data;
  logic [CountW-1:0] sh_count;
  logic              sh_parity;
`ifdef SERIAL_LOADER_PARITY_EN
  logic              frame_err_q, frame_err_d;
`endif

  serial_shifter #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .CountW    (CountW)
  ) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .clear    (clear),
    .bit_in   (bit_in),
    .data     (sh_data),
    .count    (sh_count),
    .parity   (sh_parity)
  );

  assign bit_ready = (state_q != ST_COMMIT);
  assign transfer  = bit_valid & bit_ready;
  assign last_bit  = (sh_count == CountW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    shift_en = 1'b0;
    clear    = 1'b0;
`ifdef SERIAL_LOADER_PARITY_EN
    frame_err_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE, ST_SHIFT: begin
        if (transfer) begin
          shift_en = 1'b1;
          if (last_bit) begin
`ifdef SERIAL_LOADER_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_COMMIT;
`endif
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
`ifdef SERIAL_LOADER_PARITY_EN
      ST_PARITY: begin
        if (transfer) begin
          // Running parity of the data bits must equal the received parity bit.
          if (sh_parity ^ bit_in) begin
            frame_err_d = 1'b1;
            clear       = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_COMMIT;
          end
        end
      end
`endif
      ST_COMMIT: begin
        word_d  = sh_data;
        clear   = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        clear   = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      busy_q  <= in_frame(state_d);
    end
  end

`ifdef SERIAL_LOADER_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
    end
  end
  assign frame_err = frame_err_q;
`else
  logic unused_parity;
  assign unused_parity = sh_parity;
  assign frame_err     = 1'b0;
`endif

  // The completed word is shown straight from the shifter during COMMIT, then held in word_q.
  assign word_out = (state_q == ST_COMMIT) ? sh_data : word_q;
  assign load     = (state_q == ST_COMMIT);
  assign busy     = busy_q;

endmodule

// File: tb/tb_serial_word_loader.sv
// Randomized self-checking bench for serial_word_loader (MSB-first and LSB-first instances).
// Honours SERIAL_LOADER_PARITY_EN in the same way as the design.
module tb_serial_word_loader;

  localparam int unsigned W = 16;
`ifdef SERIAL_LOADER_PARITY_EN
  localparam int unsigned FrameBits = W + 1;
`else
  localparam int unsigned FrameBits = W;
`endif

  logic         clk, reset, bit_in, bit_valid;
  logic         m_ready_o, m_load_o, m_busy_o, m_ferr_o;
  logic [W-1:0] m_word_o;
  logic         l_ready_o, l_load_o, l_busy_o, l_ferr_o;
  logic [W-1:0] l_word_o;

  serial_word_loader #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk       (clk),
    .reset     (reset),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (m_ready_o),
    .word_out  (m_word_o),
    .load      (m_load_o),
    .busy      (m_busy_o),
    .frame_err (m_ferr_o)
  );

  serial_word_loader #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk       (clk),
    .reset     (reset),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (l_ready_o),
    .word_out  (l_word_o),
    .load      (l_load_o),
    .busy      (l_busy_o),
    .frame_err (l_ferr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: received bits of the current frame plus expected outputs.
  logic         frame_q[$];
  logic         exp_load, exp_busy, exp_ready, exp_ferr;
  logic [W-1:0] exp_word_msb, exp_word_lsb;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("msb_load",  32'(m_load_o),  32'(exp_load));
    check_eq("msb_word",  32'(m_word_o),  32'(exp_word_msb));
    check_eq("msb_busy",  32'(m_busy_o),  32'(exp_busy));
    check_eq("msb_ready", 32'(m_ready_o), 32'(exp_ready));
    check_eq("msb_ferr",  32'(m_ferr_o),  32'(exp_ferr));
    check_eq("lsb_load",  32'(l_load_o),  32'(exp_load));
    check_eq("lsb_word",  32'(l_word_o),  32'(exp_word_lsb));
    check_eq("lsb_busy",  32'(l_busy_o),  32'(exp_busy));
    check_eq("lsb_ready", 32'(l_ready_o), 32'(exp_ready));
  endtask

  task automatic model_reset();
    frame_q.delete();
    exp_load     = 1'b0;
    exp_busy     = 1'b0;
    exp_ready    = 1'b1;
    exp_ferr     = 1'b0;
    exp_word_msb = '0;
    exp_word_lsb = '0;
  endtask

  task automatic model_edge(input logic xfer, input logic b);
    logic par;
    exp_ferr = 1'b0;
    if (exp_load) begin
      exp_load  = 1'b0;
      exp_ready = 1'b1;
      exp_busy  = 1'b0;
    end else if (xfer) begin
      frame_q.push_back(b);
      exp_busy = 1'b1;
      if (frame_q.size() == FrameBits) begin
        par = 1'b0;
        foreach (frame_q[i]) par ^= frame_q[i];
        if (FrameBits > W && par) begin
          exp_ferr = 1'b1;
          exp_busy = 1'b0;
        end else begin
          for (int i = 0; i < W; i++) begin
            exp_word_msb[W-1-i] = frame_q[i];
            exp_word_lsb[i]     = frame_q[i];
          end
          exp_load  = 1'b1;
          exp_ready = 1'b0;
        end
        frame_q.delete();
      end
    end
  endtask

  // One clock: drive inputs, predict the edge, then compare just after it.
  task automatic step(input logic v, input logic b);
    logic xfer;
    bit_valid = v;
    bit_in    = b;
    xfer      = v && exp_ready;
    @(posedge clk);
    #1;
    model_edge(xfer, b);
    check_outputs();
  endtask

  task automatic send_bit(input logic b);
    int  guard;
    logic xfer_now;
    guard = 0;
    forever begin
      xfer_now = exp_ready;
      step(1'b1, b);
      if (xfer_now) break;
      guard++;
      if (guard > 4) begin
        check_eq("stall_bound", 32'(guard), 32'd4);
        break;
      end
    end
  endtask

  task automatic send_word(input logic [W-1:0] word, input int gap, input logic bad_par);
    for (int i = 0; i < W; i++) begin
      send_bit(word[W-1-i]);
      if (i != W - 1 || FrameBits > W) begin
        for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom));
      end
    end
    if (FrameBits > W) send_bit((^word) ^ bad_par);
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    bit_valid = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    reset     = 1'b1;
    model_reset();
    #2;
    apply_reset();

    // Basic word with valid held high.
    send_word(16'hA5C3, 0, 1'b0);
    check_eq("basic_word", 32'(m_word_o), 32'h0000_A5C3);
    check_eq("basic_load", 32'(m_load_o), 32'd1);
    step(1'b0, 1'b0);
    check_eq("basic_load_off", 32'(m_load_o), 32'd0);

    // Valid only every third cycle.
    send_word(16'h0001, 2, 1'b0);
    check_eq("gapped_word", 32'(m_word_o), 32'h0000_0001);
    step(1'b0, 1'b0);

    // Back-to-back words; the first bit of the second word stalls through COMMIT.
    send_word(16'hFFFF, 0, 1'b0);
    check_eq("b2b_first", 32'(m_word_o), 32'h0000_FFFF);
    send_word(16'h1234, 0, 1'b0);
    check_eq("b2b_second", 32'(m_word_o), 32'h0000_1234);
    step(1'b0, 1'b0);

    // Reset after 7 bits, then a clean word.
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    apply_reset();
    check_eq("rst_word", 32'(m_word_o), 32'd0);
    send_word(16'h00FF, 0, 1'b0);
    check_eq("after_rst_word", 32'(m_word_o), 32'h0000_00FF);
    step(1'b0, 1'b0);

    // Bits 1,0,...,0 into the LSB-first instance.
    send_word(16'h8000, 1, 1'b0);
    check_eq("lsb_first_word", 32'(l_word_o), 32'h0000_0001);
    step(1'b0, 1'b0);

`ifdef SERIAL_LOADER_PARITY_EN
    send_word(16'h0003, 0, 1'b0);
    check_eq("par_ok_word", 32'(m_word_o), 32'h0000_0003);
    step(1'b0, 1'b0);
    send_word(16'h0007, 0, 1'b1);
    check_eq("par_bad_ferr", 32'(m_ferr_o), 32'd1);
    check_eq("par_bad_word", 32'(m_word_o), 32'h0000_0003);
    step(1'b0, 1'b0);
    check_eq("par_bad_ferr_off", 32'(m_ferr_o), 32'd0);
`endif

    // Random words, gaps and (with parity) occasional bad frames.
    for (int n = 0; n < 40; n++) begin
      send_word(W'($urandom), int'($urandom_range(0, 2)), 1'($urandom_range(0, 3) == 0));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) step(1'b0, 1'($urandom));
    end

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
